// File: rtl/alu_flag_capture_pkg.sv
// alu_flag_capture_pkg: condition codes and flag bit positions shared by the ALU capture stage.
package alu_flag_capture_pkg;
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_PS = 4'd14;
  localparam logic [3:0] COND_AL = 4'd15;
  localparam int FLG_S = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_P = 1;
  localparam int FLG_V = 0;
endpackage

// File: rtl/alu_flag_capture_cond_eval.sv
// alu_cond_eval: combinational branch condition from the five ALU flags.
module alu_cond_eval
  import alu_flag_capture_pkg::*;
(
  input  logic [4:0] flags,
  input  logic [3:0] cond_sel,
  output logic       cond
);
  logic n, z, c, p, v;
  assign n = flags[FLG_S];
  assign z = flags[FLG_Z];
  assign c = flags[FLG_C];
  assign p = flags[FLG_P];
  assign v = flags[FLG_V];
  always_comb begin
    cond = 1'b1;
    case (cond_sel)
      COND_EQ: cond = z;
      COND_NE: cond = !z;
      COND_CS: cond = c;
      COND_CC: cond = !c;
      COND_MI: cond = n;
      COND_PL: cond = !n;
      COND_VS: cond = v;
      COND_VC: cond = !v;
      COND_HI: cond = c & !z;
      COND_LS: cond = !c | z;
      COND_GE: cond = n == v;
      COND_LT: cond = n != v;
      COND_GT: cond = !z & (n == v);
      COND_LE: cond = z | (n != v);
      COND_PS: cond = p;
      default: cond = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_flag_capture.sv
// alu_flag_capture: captures ALU result/flags with a branch condition into a small FIFO and
// tracks sticky overflow status with a saturating counter.
module alu_flag_capture
  import alu_flag_capture_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] z,
  input  logic             sign,
  input  logic             zero,
  input  logic             carry,
  input  logic             parity,
  input  logic             overflow,
  input  logic [3:0]       cond_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic [4:0]       out_flags,
  output logic             out_cond,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] ovf_count
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic [4:0]       flags;
    logic             cond;
  } entry_t;
  entry_t          mem [DEPTH];
  entry_t          in_e, head_e, out_e;
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_n;
  logic [AW:0]     count, count_n;
  logic            push, pop, cond;
  logic [4:0]      flags;
  assign flags = {sign, zero, carry, parity, overflow};
  alu_cond_eval u_cond (
    .flags   (flags),
    .cond_sel(cond_sel),
    .cond    (cond)
  );
  assign in_e      = '{z: z, flags: flags, cond: cond};
  assign in_ready  = count != (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign rd_n      = pop ? rd_ptr + 1'b1 : rd_ptr;
  assign count_n   = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  // The output register tracks the head after this edge; a push into a drained slot is the new head.
  assign head_e    = (push && rd_n == wr_ptr) ? in_e : mem[rd_n];
  assign out_z     = out_e.z;
  assign out_flags = out_e.flags;
  assign out_cond  = out_e.cond;
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_e;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_e      <= '0;
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_n;
      count  <= count_n;
      if (count_n != '0) out_e <= head_e;
      if (push && overflow) begin
        sticky_ovf <= 1'b1;
        ovf_count  <= clr_sticky ? CNT_W'(1) : (&ovf_count ? ovf_count : ovf_count + 1'b1);
      end else if (clr_sticky) begin
        sticky_ovf <= 1'b0;
        ovf_count  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_flag_capture.sv
// tb_alu_flag_capture: directed tables, multi-cycle corner sequences and a randomized queue model.
module tb_alu_flag_capture;
  import alu_flag_capture_pkg::*;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_cond, clr_sticky, sticky_ovf;
  logic [WIDTH-1:0] z, out_z;
  logic [4:0] fl, out_flags;
  logic [3:0] cond_sel;
  logic [CNT_W-1:0] ovf_count;
  int cmp = 0;
  int bad = 0;
  typedef struct {logic [15:0] z; logic [4:0] f; logic [3:0] c; logic e;} vec_t;
  typedef struct {logic [15:0] z; logic [4:0] f; logic c;} ent_t;
  vec_t tbl[$];
  ent_t q[$];
  ent_t last, shown, popped;
  int m_cnt;
  logic m_sticky;
  always #5 clk = ~clk;
  alu_flag_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .z(z),
    .sign(fl[4]), .zero(fl[3]), .carry(fl[2]), .parity(fl[1]), .overflow(fl[0]),
    .cond_sel(cond_sel), .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_flags(out_flags), .out_cond(out_cond), .clr_sticky(clr_sticky),
    .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Codes pair up as condition / complement; PS and AL stand alone.
  function automatic logic ref_cond(input logic [4:0] f, input logic [3:0] c);
    logic n, zz, cy, p, v, base;
    {n, zz, cy, p, v} = f;
    base = 1'b0;
    if (c == 4'd15) return 1'b1;
    if (c == 4'd14) return p;
    case (c[3:1])
      3'd0: base = zz;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !zz;
      3'd5: base = (n == v);
      default: base = !zz && (n == v);
    endcase
    return c[0] ? !base : base;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [15:0] zv, input logic [4:0] f, input logic [3:0] c);
    in_valid = 1'b1;
    z = zv;
    fl = f;
    cond_sel = c;
  endtask
  initial begin
    int acc, n;
    logic iv, ordy, clr, rs, psh, pp;
    in_valid = 0; out_ready = 0; clr_sticky = 0; fl = 0; z = 0; cond_sel = 0;
    rst = 1; tick(); tick(); rst = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_z", out_z, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_cond", out_cond, 0);
    check("rst_sticky", sticky_ovf, 0);
    check("rst_count", ovf_count, 0);
    drive(16'h0fff, 5'b00101, COND_VS); tick(); in_valid = 0;
    check("t1_valid", out_valid, 1);
    check("t1_z", out_z, 16'h0fff);
    check("t1_flags", out_flags, 5'b00101);
    check("t1_cond", out_cond, 1);
    check("t1_sticky", sticky_ovf, 1);
    check("t1_count", ovf_count, 1);
    out_ready = 1; tick(); out_ready = 0;
    check("t1_drained", out_valid, 0);
    check("t1_hold_z", out_z, 16'h0fff);
    drive(16'h0000, 5'b01110, COND_HI); tick();
    check("t2_ready1", in_ready, 1);
    drive(16'hffff, 5'b10010, COND_LT); tick(); in_valid = 0;
    check("t2_full", in_ready, 0);
    check("t2_head_z", out_z, 16'h0000);
    check("t2_head_cond", out_cond, 0);
    tick(); tick();
    check("t2_stall_z", out_z, 16'h0000);
    check("t2_stall_flags", out_flags, 5'b01110);
    check("t2_stall_valid", out_valid, 1);
    drive(16'h1234, 5'b00000, COND_AL); out_ready = 1;
    check("t3_blocked", in_ready, 0);
    tick();
    check("t3_pop_z", out_z, 16'hffff);
    check("t3_pop_cond", out_cond, 1);
    check("t3_ready_after_pop", in_ready, 1);
    out_ready = 0; tick(); in_valid = 0;
    check("t3_push_late", in_ready, 0);
    out_ready = 1; tick();
    check("t3_second_z", out_z, 16'h1234);
    check("t3_second_cond", out_cond, 1);
    tick();
    check("t3_no_dup", out_valid, 0);
    check("t3_count", ovf_count, 1);
    for (int i = 0; i < 4; i++) begin
      drive(16'(i), 5'b00001, COND_AL); tick();
    end
    check("t4_count5", ovf_count, 5);
    clr_sticky = 1; tick(); in_valid = 0;
    check("t4_set_wins_sticky", sticky_ovf, 1);
    check("t4_set_wins_count", ovf_count, 1);
    tick(); clr_sticky = 0;
    check("t4_clr_sticky", sticky_ovf, 0);
    check("t4_clr_count", ovf_count, 0);
    acc = 0; n = 0;
    drive(16'h8000, 5'b00001, COND_VS);
    while (acc < 300 && n < 1000) begin
      if (in_ready) acc++;
      tick(); n++;
    end
    in_valid = 0;
    check("t5_accepts", acc, 300);
    check("t5_saturate", ovf_count, 8'hff);
    tick(); tick(); out_ready = 0;
    drive(16'haaaa, 5'b00001, COND_EQ); tick(); tick();
    check("t6_full", in_ready, 0);
    out_ready = 1; rst = 1; tick(); rst = 0; in_valid = 0; out_ready = 0;
    check("t6_valid", out_valid, 0);
    check("t6_ready", in_ready, 1);
    check("t6_z", out_z, 0);
    check("t6_sticky", sticky_ovf, 0);
    check("t6_count", ovf_count, 0);
    tbl.push_back('{16'h0fff, 5'b00101, COND_VS, 1'b1});
    tbl.push_back('{16'h0000, 5'b01110, COND_HI, 1'b0});
    tbl.push_back('{16'hffff, 5'b10010, COND_LT, 1'b1});
    tbl.push_back('{16'h0000, 5'b01110, COND_EQ, 1'b1});
    tbl.push_back('{16'h0fff, 5'b00101, COND_GE, 1'b0});
    tbl.push_back('{16'hffff, 5'b10010, COND_GT, 1'b0});
    tbl.push_back('{16'h0fff, 5'b00101, COND_LE, 1'b1});
    tbl.push_back('{16'h0000, 5'b01110, COND_PS, 1'b1});
    for (int c = 0; c < 16; c++) begin
      tbl.push_back('{16'h0fff, 5'b00101, 4'(c), ref_cond(5'b00101, 4'(c))});
      tbl.push_back('{16'h0000, 5'b01110, 4'(c), ref_cond(5'b01110, 4'(c))});
      tbl.push_back('{16'hffff, 5'b10010, 4'(c), ref_cond(5'b10010, 4'(c))});
    end
    foreach (tbl[i]) begin
      drive(tbl[i].z, tbl[i].f, tbl[i].c); tick(); in_valid = 0;
      check($sformatf("tbl%0d_z", i), out_z, tbl[i].z);
      check($sformatf("tbl%0d_flags", i), out_flags, tbl[i].f);
      check($sformatf("tbl%0d_cond_sel%0d", i, tbl[i].c), out_cond, tbl[i].e);
      out_ready = 1; tick(); out_ready = 0;
    end
    rst = 1; tick(); rst = 0;
    q.delete(); last = '{0, 0, 0}; m_cnt = 0; m_sticky = 0;
    for (int k = 0; k < 3000; k++) begin
      shown = q.size() > 0 ? q[0] : last;
      check("rnd_out_valid", out_valid, q.size() > 0);
      check("rnd_in_ready", in_ready, q.size() < DEPTH);
      check("rnd_out_z", out_z, shown.z);
      check("rnd_out_flags", out_flags, shown.f);
      check("rnd_out_cond", out_cond, shown.c);
      check("rnd_sticky", sticky_ovf, m_sticky);
      check("rnd_count", ovf_count, m_cnt);
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 2) != 0;
      clr = $urandom_range(0, 15) == 0;
      rs = $urandom_range(0, 199) == 0;
      drive(16'($urandom), 5'($urandom), 4'($urandom));
      in_valid = iv; out_ready = ordy; clr_sticky = clr; rst = rs;
      if (rs) begin
        q.delete(); last = '{0, 0, 0}; m_cnt = 0; m_sticky = 0;
      end else begin
        psh = iv && q.size() < DEPTH;
        pp = ordy && q.size() > 0;
        if (pp) begin
          popped = q.pop_front();
          last = popped;
        end
        if (psh) q.push_back('{z, fl, ref_cond(fl, cond_sel)});
        if (q.size() > 0) last = q[0];
        if (psh && fl[0]) begin
          m_sticky = 1;
          m_cnt = clr ? 1 : (m_cnt == 255 ? 255 : m_cnt + 1);
        end else if (clr) begin
          m_sticky = 0;
          m_cnt = 0;
        end
      end
      tick();
    end
    rst = 0; in_valid = 0; out_ready = 0; clr_sticky = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
